// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FIFO behind a UART receiver, first-word-fall-through read port
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rx_data, rx_done     byte and byte-complete flag from the receiver; one push per rx_done rising edge
//   rd_data, rd_valid    head-of-FIFO byte and non-empty flag (FWFT)
//   rd_ready             consumer accepts rd_data this cycle
//   count, full, empty   occupancy 0..DEPTH and its derived flags
//   overflow, ovf_clr    sticky drop flag and its synchronous clear
//   ovf_count            saturating drop counter, present only when UART_RX_FIFO_OVF_CNT_EN is defined
module uart_rx_fifo #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   input  logic              ovf_clr
`ifdef UART_RX_FIFO_OVF_CNT_EN
   ,output logic [7:0]       ovf_count
`endif
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              rx_done_q, overflow_q, overflow_d;
   logic              push_req, pop, push, drop;
   assign full     = count_q == FULL_CNT;
   assign empty    = count_q == '0;
   assign rd_valid = ~empty;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign rd_data  = mem_q[rd_ptr_q];
   // A pop frees the head slot in the same cycle, so a push into a full FIFO is accepted when paired with a pop
   always_comb begin
      push_req   = rx_done & ~rx_done_q;
      pop        = rd_valid & rd_ready;
      push       = push_req & (~full | pop);
      drop       = push_req & full & ~pop;
      wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      count_d    = (push & ~pop) ? count_q + (ADDR_W+1)'(1) :
                   (pop & ~push) ? count_q - (ADDR_W+1)'(1) : count_q;
      overflow_d = drop | (overflow_q & ~ovf_clr);
   end
   // rx_done_q resets high so a level already asserted at reset release is not taken as an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rx_done_q  <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rx_done_q  <= rx_done;
         overflow_q <= overflow_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rx_data;
   end
`ifdef UART_RX_FIFO_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;
   // A drop coinciding with a clear leaves the counter at one
   always_comb begin
      ovf_cnt_d = ovf_clr ? {7'd0, drop} :
                  (drop && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_cnt_q <= '0;
      else     ovf_cnt_q <= ovf_cnt_d;
   end
   assign ovf_count = ovf_cnt_q;
`endif
endmodule
